ufi_ram_stream_reader: RTL and testbench

//  UFI bus master that reads contiguous SRAM words through RAMBlock's UFI slave port and streams them out in order.
//  A start command gives a start address and a word count; the block issues read requests with flow control.

---
 rtl/ufi_pkg.sv | 22 ++
 rtl/ufi_stream_fifo.sv | 69 ++++++
 rtl/ufi_ram_stream_reader.sv | 215 +++++++++++++++++++++
 tb/tb_ufi_ram_stream_reader.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ufi_pkg.sv
// ---------------------------------------------------------------------------
// ufi_pkg
// Shared UFI bus constants and the state encoding of the stream reader.
//   lpUfiEnBit  : request/response valid bit of the UFI address/control bus
//   lpUfiCmdBit : command bit (0 = read, 1 = write)
//   reader_state_t : stream reader FSM states
// ---------------------------------------------------------------------------
package ufi_pkg;

    localparam int lpUfiEnBit  = 31;
    localparam int lpUfiCmdBit = 30;
    localparam int lpUfiCmdRd  = 0;
    localparam int lpUfiCmdWr  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/ufi_stream_fifo.sv
// ---------------------------------------------------------------------------
// ufi_stream_fifo
// Synchronous first-word-fall-through FIFO. The head word is visible on
// 'head' whenever 'empty' is low; 'pop' consumes it on the next edge.
// Ports:
//   clk, rst          : clock, synchronous active-high clear
//   push, push_data   : write strobe and word
//   pop               : consume head (ignored when empty)
//   head              : current head word
//   count, full, empty: occupancy and flags
// pDepth must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ufi_stream_fifo #(
    parameter int pDepth = 64,
    parameter int pWidth = 16,
    localparam int lpPtrW = $clog2(pDepth),
    localparam int lpCntW = lpPtrW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [pWidth-1:0] push_data,
    input  logic              pop,
    output logic [pWidth-1:0] head,
    output logic [lpCntW-1:0] count,
    output logic              full,
    output logic              empty
);

    logic [pWidth-1:0] mem [pDepth];
    logic [lpPtrW-1:0] wr_ptr;
    logic [lpPtrW-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == lpCntW'(pDepth));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is still legal when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + lpPtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + lpPtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + lpCntW'(1);
                2'b01:   count <= count - lpCntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ufi_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ufi_ram_stream_reader
// UFI bus master that reads a contiguous run of SRAM words and streams them
// out in order through a local FWFT FIFO. Requests are only issued while a
// FIFO slot is reserved for the answer (credit), so returns never overflow.
// Ports:
//   iSCLK, iSRST              : clock, synchronous active-high reset
//   iStart/iStartAdrs/iLen    : start command (sampled only when idle)
//   oBusy, oDone              : transfer in progress / one-cycle completion
//   oMUfiWd, oMUfiAdrs        : request to the slave ([31]=valid,[30]=cmd)
//   iMUfiRdy                  : slave accepts the presented request
//   iMUfiRd, iMUfiAdrs        : read return data / [31]=return valid
//   oStrmD, oStrmVd, iStrmRe  : consumer stream (FWFT)
//   oErr                      : sticky error (stale return / bad address)
// Optional feature macro: UFI_STREAM_READER_ADRS_CHECK_EN enables checking
// of the returned address against the expected word address.
// ---------------------------------------------------------------------------
module ufi_ram_stream_reader
    import ufi_pkg::*;
#(
    parameter int pUfiDqBusWidth   = 16,
    parameter int pUfiAdrsBusWidth = 32,
    parameter int pUfiEnableBit    = 32,
    parameter int pRamAdrsWidth    = 18,
    parameter int pLenWidth        = 16,
    parameter int pFifoDepth       = 64
) (
    input  logic                        iSCLK,
    input  logic                        iSRST,
    input  logic                        iStart,
    input  logic [pRamAdrsWidth-1:0]    iStartAdrs,
    input  logic [pLenWidth-1:0]        iLen,
    output logic                        oBusy,
    output logic                        oDone,
    output logic [pUfiDqBusWidth-1:0]   oMUfiWd,
    output logic [pUfiAdrsBusWidth-1:0] oMUfiAdrs,
    input  logic                        iMUfiRdy,
    input  logic [pUfiDqBusWidth-1:0]   iMUfiRd,
    input  logic [pUfiAdrsBusWidth-1:0] iMUfiAdrs,
    output logic [pUfiDqBusWidth-1:0]   oStrmD,
    output logic                        oStrmVd,
    input  logic                        iStrmRe,
    output logic                        oErr
);

    localparam int lpCrW = $clog2(pFifoDepth) + 1;

    reader_state_t              state;
    reader_state_t              state_next;
    logic [pRamAdrsWidth-1:0]   adrs;
    logic [pLenWidth-1:0]       remaining;
    logic [pLenWidth-1:0]       received;
    logic [pLenWidth-1:0]       received_next;
    logic [pLenWidth-1:0]       total;
    logic [lpCrW-1:0]           credit;
    logic                       start_accept;
    logic                       active;
    logic                       req_valid;
    logic                       req_hs;
    logic                       rsp_valid;
    logic                       rsp_push;
    logic                       stale;
    logic                       pop;
    logic                       all_req_done;
    logic                       all_rsp_done;
    logic                       adrs_mismatch;
    logic                       err;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [lpCrW-1:0]           fifo_count;
    logic                       unused_bits;

    assign start_accept  = (state == ST_IDLE) && iStart;
    assign active        = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign rsp_valid     = iMUfiAdrs[pUfiEnableBit-1];
    // Returns outside a transfer belong to an aborted or unknown request.
    assign rsp_push      = rsp_valid & active;
    assign stale         = rsp_valid & ~active;
    assign pop           = iStrmRe & ~fifo_empty;
    assign req_valid     = (state == ST_ISSUE) && (remaining != '0) && (credit != '0);
    assign req_hs        = req_valid & iMUfiRdy;
    assign received_next = received + pLenWidth'(rsp_push);
    assign all_req_done  = (remaining == '0) || (req_hs && (remaining == pLenWidth'(1)));
    assign all_rsp_done  = (received_next == total);
    assign unused_bits   = ^{iMUfiAdrs, fifo_full, fifo_count};

    // State register.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero-length start goes straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    state_next = (iLen == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (all_req_done) begin
                    state_next = all_rsp_done ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (all_rsp_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic; the bus word is all-zero whenever no request is valid.
    always_comb begin
        oBusy     = (state != ST_IDLE);
        oDone     = (state == ST_DONE);
        oMUfiWd   = '0;
        oMUfiAdrs = '0;
        if (req_valid) begin
            oMUfiAdrs[pUfiEnableBit-1]   = 1'b1;
            oMUfiAdrs[lpUfiCmdBit]       = 1'(lpUfiCmdRd);
            oMUfiAdrs[pRamAdrsWidth-1:0] = adrs;
        end
    end

    // Address, remaining and received counters for the current transfer.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            adrs      <= '0;
            remaining <= '0;
            received  <= '0;
            total     <= '0;
        end else if (start_accept) begin
            adrs      <= iStartAdrs;
            remaining <= iLen;
            received  <= '0;
            total     <= iLen;
        end else begin
            if (req_hs) begin
                adrs      <= adrs + pRamAdrsWidth'(1);
                remaining <= remaining - pLenWidth'(1);
            end
            received <= received_next;
        end
    end

    // Credit = FIFO slots not yet promised to an outstanding or stored word.
    // It survives DONE because unread words still occupy the FIFO.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            credit <= lpCrW'(pFifoDepth);
        end else begin
            case ({req_hs, pop})
                2'b10:   credit <= credit - lpCrW'(1);
                2'b01:   credit <= credit + lpCrW'(1);
                default: credit <= credit;
            endcase
        end
    end

`ifdef UFI_STREAM_READER_ADRS_CHECK_EN
    logic [pRamAdrsWidth-1:0] exp_adrs;

    // Returns arrive in request order, so the expected address just counts.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            exp_adrs <= '0;
        end else if (start_accept) begin
            exp_adrs <= iStartAdrs;
        end else if (rsp_push) begin
            exp_adrs <= exp_adrs + pRamAdrsWidth'(1);
        end
    end

    assign adrs_mismatch = rsp_push && (iMUfiAdrs[pRamAdrsWidth-1:0] != exp_adrs);
`else
    assign adrs_mismatch = 1'b0;
`endif

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            err <= 1'b0;
        end else if (stale || adrs_mismatch) begin
            err <= 1'b1;
        end
    end

    assign oErr = err;

    ufi_stream_fifo #(
        .pDepth (pFifoDepth),
        .pWidth (pUfiDqBusWidth)
    ) u_fifo (
        .clk       (iSCLK),
        .rst       (iSRST),
        .push      (rsp_push),
        .push_data (iMUfiRd),
        .pop       (pop),
        .head      (oStrmD),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign oStrmVd = ~fifo_empty;

endmodule

// File: tb/tb_ufi_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ufi_ram_stream_reader
// Bench for the stream reader with a 4-deep FIFO. A randomized UFI slave
// answers the requests the DUT presents; a transaction-level model predicts
// every output each cycle from the start command, credit arithmetic and a
// queue of expected stream words.
// ---------------------------------------------------------------------------
module tb_ufi_ram_stream_reader;

    localparam int DEPTH = 4;
    localparam int AW    = 18;
    localparam int LW    = 16;
    localparam int DW    = 16;
    localparam int UW    = 32;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } pend_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_adrs = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] m_wd;
    logic [UW-1:0] m_adrs_out;
    logic          rdy = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic [UW-1:0] rd_adrs = '0;
    logic [DW-1:0] strm_d;
    logic          strm_vd;
    logic          strm_re = 1'b0;
    logic          err;

    // Bench knobs and logs
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            rdy_prob = 100;
    int            pop_prob = 100;
    int            lat_max = 2;
    int            stale_inject = 0;
    bit            pop_force = 0;
    bit            corrupt_next = 0;
    int            done_count = 0;
    int            ret_count = 0;
    pend_t         pend[$];
    logic [AW-1:0] acc_log[$];
    logic [DW-1:0] pop_log[$];

    // Snapshots of DUT outputs taken mid-cycle
    logic [UW-1:0] snap_req = '0;
    logic          snap_vd = 1'b0;
    logic [DW-1:0] snap_d = '0;
    logic          snap_done = 1'b0;

    // Behavioural model
    bit            m_ok = 0;
    bit            m_busy = 0;
    bit            m_issuing = 0;
    bit            m_done = 0;
    bit            m_err = 0;
    int            m_rem = 0;
    int            m_total = 0;
    int            m_recv = 0;
    int            m_issued = 0;
    int            m_popped = 0;
    logic [AW-1:0] m_next = '0;
    logic [AW-1:0] m_ret = '0;
    logic [DW-1:0] m_q[$];

    always #5 clk = ~clk;

    ufi_ram_stream_reader #(
        .pUfiDqBusWidth   (DW),
        .pUfiAdrsBusWidth (UW),
        .pUfiEnableBit    (32),
        .pRamAdrsWidth    (AW),
        .pLenWidth        (LW),
        .pFifoDepth       (DEPTH)
    ) dut (
        .iSCLK      (clk),
        .iSRST      (rst),
        .iStart     (start),
        .iStartAdrs (start_adrs),
        .iLen       (len),
        .oBusy      (busy),
        .oDone      (done),
        .oMUfiWd    (m_wd),
        .oMUfiAdrs  (m_adrs_out),
        .iMUfiRdy   (rdy),
        .iMUfiRd    (rd_data),
        .iMUfiAdrs  (rd_adrs),
        .oStrmD     (strm_d),
        .oStrmVd    (strm_vd),
        .iStrmRe    (strm_re),
        .oErr       (err)
    );

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return a[15:0] ^ {a[17:16], 14'h0A5} ^ 16'h5A3C;
    endfunction

    function automatic bit exp_req_valid();
        return m_busy && !m_done && m_issuing && (m_rem > 0) && ((DEPTH - (m_issued - m_popped)) > 0);
    endfunction

    function automatic logic [UW-1:0] exp_req_word();
        if (exp_req_valid()) return {1'b1, 1'b0, 12'd0, m_next};
        return '0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string nm);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // Advance the model by one clock edge using the inputs of the ending cycle.
    task automatic model_step();
        bit hs;
        bit pop_now;
        bit rsp;
        if (rst) begin
            m_ok = 1; m_busy = 0; m_issuing = 0; m_done = 0; m_err = 0;
            m_rem = 0; m_total = 0; m_recv = 0; m_issued = 0; m_popped = 0;
            m_q.delete();
            return;
        end
        if (!m_ok) return;
        hs      = exp_req_valid() && rdy;
        pop_now = strm_re && (m_q.size() > 0);
        rsp     = rd_adrs[UW-1];
        if (pop_now) begin
            void'(m_q.pop_front());
            m_popped++;
        end
        if (!m_busy) begin
            if (rsp) m_err = 1;
            if (start) begin
                m_busy = 1;
                if (len == 0) begin
                    m_done = 1;
                end else begin
                    m_issuing = 1;
                    m_rem = int'(len); m_total = int'(len); m_recv = 0;
                    m_next = start_adrs; m_ret = start_adrs;
                end
            end
        end else if (m_done) begin
            if (rsp) m_err = 1;
            m_done = 0;
            m_busy = 0;
        end else begin
            if (hs) begin
                m_rem--;
                m_next = m_next + 1'b1;
                m_issued++;
            end
            if (rsp) begin
                m_q.push_back(data_of(m_ret));
`ifdef UFI_STREAM_READER_ADRS_CHECK_EN
                if (rd_adrs[AW-1:0] != m_ret) m_err = 1;
`endif
                m_ret = m_ret + 1'b1;
                m_recv++;
            end
            if (m_recv == m_total) begin
                m_done = 1;
                m_issuing = 0;
            end else if (m_rem == 0) begin
                m_issuing = 0;
            end
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        snap_req  = m_adrs_out;
        snap_vd   = strm_vd;
        snap_d    = strm_d;
        snap_done = done;
        if (m_ok) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("strm_vd", 32'(strm_vd), 32'(m_q.size() > 0));
            if (m_q.size() > 0) check("strm_d", 32'(strm_d), 32'(m_q[0]));
            check("req", m_adrs_out, exp_req_word());
            check("wd", 32'(m_wd), 32'd0);
        end
    end

    // Slave, consumer and model clocking; next-cycle inputs driven 1 after the edge.
    always @(posedge clk) begin : drive_blk
        pend_t p;
        if (snap_req[UW-1] && rdy) begin
            p.a   = snap_req[AW-1:0];
            p.due = cyc + 1 + int'($urandom_range(0, lat_max));
            pend.push_back(p);
            acc_log.push_back(p.a);
        end
        if (strm_re && snap_vd) pop_log.push_back(snap_d);
        if (rd_adrs[UW-1]) ret_count++;
        if (snap_done) done_count++;
        model_step();
        if (rst) pend.delete();
        cyc++;
        #1;
        rdy = (int'($urandom_range(0, 99)) < rdy_prob);
        if (pop_force) begin
            strm_re = 1'b1;
            pop_force = 0;
        end else begin
            strm_re = (int'($urandom_range(0, 99)) < pop_prob);
        end
        rd_adrs = '0;
        rd_data = '0;
        if (stale_inject > 0) begin
            rd_adrs = {1'b1, 13'd0, 18'h00155};
            rd_data = 16'hDEAD;
            stale_inject--;
        end else if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            rd_adrs = {1'b1, 13'd0, pend[0].a};
            rd_data = data_of(pend[0].a);
            if (corrupt_next) begin
                rd_adrs[0] = ~rd_adrs[0];
                corrupt_next = 0;
            end
            void'(pend.pop_front());
        end
    end

    task automatic start_xfer(input logic [AW-1:0] a, input int n);
        @(posedge clk); #1;
        start = 1'b1; start_adrs = a; len = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string nm);
        int k;
        k = 0;
        while ((done_count <= d0) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (done_count <= d0) fail_timeout(nm);
    endtask

    // Drain stream and slave so the next start is sampled in IDLE with full credit.
    task automatic settle(input string nm);
        int k;
        k = 0;
        pop_prob = 100;
        while (((m_q.size() > 0) || (pend.size() > 0) || m_busy) && (k < 400)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) fail_timeout(nm);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int d0;
        int r0;
        int k;
        int n;
        logic [AW-1:0] a;
        logic [AW-1:0] ea;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_vd", 32'(strm_vd), 32'd0);
        check("reset_req", m_adrs_out, 32'd0);

        // Back-to-back 8-word read
        $display("[TB] test 1: 8 words from 0x10");
        acc_log.delete(); pop_log.delete();
        rdy_prob = 100; pop_prob = 100; lat_max = 2;
        d0 = done_count;
        start_xfer(18'h00010, 8);
        wait_done(d0, 300, "t1_done");
        check("t1_busy_after", 32'(busy), 32'd0);
        settle("t1_settle");
        check("t1_done_pulses", 32'(done_count - d0), 32'd1);
        check("t1_req_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < acc_log.size() && i < 8; i++) check("t1_req_adrs", 32'(acc_log[i]), 32'h10 + 32'(i));
        check("t1_pop_count", 32'(pop_log.size()), 32'd8);
        if (pop_log.size() > 0) check("t1_first_word", 32'(pop_log[0]), 32'h5A89);
        for (int i = 0; i < pop_log.size() && i < 8; i++) check("t1_word", 32'(pop_log[i]), 32'(data_of(AW'(16 + i))));

        // Zero length
        $display("[TB] test 2: zero length");
        acc_log.delete();
        d0 = done_count;
        start_xfer(18'h00123, 0);
        wait_cycles(4);
        check("t2_done_pulses", 32'(done_count - d0), 32'd1);
        check("t2_req_count", 32'(acc_log.size()), 32'd0);

        // Address wrap
        $display("[TB] test 3: address wrap");
        acc_log.delete();
        d0 = done_count;
        start_xfer(18'h3FFFE, 4);
        wait_done(d0, 300, "t3_done");
        settle("t3_settle");
        check("t3_req_count", 32'(acc_log.size()), 32'd4);
        if (acc_log.size() == 4) begin
            check("t3_adrs0", 32'(acc_log[0]), 32'h3FFFE);
            check("t3_adrs1", 32'(acc_log[1]), 32'h3FFFF);
            check("t3_adrs2", 32'(acc_log[2]), 32'h00000);
            check("t3_adrs3", 32'(acc_log[3]), 32'h00001);
        end

        // Credit limit with a stalled consumer
        $display("[TB] test 4: credit limit");
        acc_log.delete();
        rdy_prob = 100; pop_prob = 0;
        d0 = done_count;
        start_xfer(18'h00200, 16);
        wait_cycles(30);
        check("t4_req_count_stalled", 32'(acc_log.size()), 32'd4);
        check("t4_req_valid_stalled", 32'(m_adrs_out[31]), 32'd0);
        pop_force = 1;
        wait_cycles(10);
        check("t4_req_count_one_pop", 32'(acc_log.size()), 32'd5);
        pop_prob = 70;
        wait_done(d0, 2000, "t4_done");
        settle("t4_settle");
        check("t4_req_count_total", 32'(acc_log.size()), 32'd16);

        // Random ready / consumer / address / length
        $display("[TB] test 5: randomized transfers");
        for (int t = 0; t < 6; t++) begin
            acc_log.delete();
            rdy_prob = 40; pop_prob = 60; lat_max = 3;
            a = AW'($urandom_range(0, 32'h3FFFF));
            if (t == 0) a = 18'h3FFF0;
            n = int'($urandom_range(1, 40));
            d0 = done_count;
            start_xfer(a, n);
            wait_done(d0, 3000, "t5_done");
            settle("t5_settle");
            check("t5_req_count", 32'(acc_log.size()), 32'(n));
            for (int i = 0; i < acc_log.size() && i < n; i++) begin
                ea = a + AW'(i);
                check("t5_req_adrs", 32'(acc_log[i]), 32'(ea));
            end
        end

        // Reset mid-transfer, then stale returns
        $display("[TB] test 6: reset mid-transfer");
        rdy_prob = 100; pop_prob = 0; lat_max = 2;
        d0 = done_count;
        r0 = ret_count;
        start_xfer(18'h00300, 10);
        k = 0;
        while ((ret_count - r0 < 3) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        if (ret_count - r0 < 3) fail_timeout("t6_three_returns");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stale_inject = 2;
        wait_cycles(12);
        check("t6_fifo_empty", 32'(strm_vd), 32'd0);
        check("t6_err", 32'(err), 32'd1);
        check("t6_no_done", 32'(done_count - d0), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_err_cleared", 32'(err), 32'd0);

        // Corrupted return address
        $display("[TB] test 7: corrupted return address");
        pop_prob = 100;
        corrupt_next = 1;
        d0 = done_count;
        start_xfer(18'h00040, 6);
        wait_done(d0, 300, "t7_done");
        settle("t7_settle");
`ifdef UFI_STREAM_READER_ADRS_CHECK_EN
        check("t7_err", 32'(err), 32'd1);
`else
        check("t7_err", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
